// File: rtl/axi_top.sv
// AXI4 loopback subsystem: command-driven write/read master engines connected
// over full AW/W/B/AR/R channels to an internal RAM-backed AXI4 slave.
module axi_top #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_wr,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [16*DATA_WIDTH-1:0] wr_data,
    input  logic [7:0]               wr_len,
    output logic                     wr_done,
    input  logic                     start_rd,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [7:0]               rd_len,
    output logic [16*DATA_WIDTH-1:0] rd_data,
    output logic                     rd_done
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] BEAT_SIZE  = 3'(BSHIFT);
    localparam logic [ID_WIDTH-1:0] MASTER_ID = '0;

    // AXI4 channels between master and slave
    logic [ID_WIDTH-1:0]   awid, bid, arid, rid;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [7:0]            awlen, arlen;
    logic [2:0]            awsize, arsize;
    logic [1:0]            awburst, arburst;
    logic                  awvalid, awready, wvalid, wready, wlast;
    logic                  bvalid, bready, arvalid, arready;
    logic                  rvalid, rready, rlast;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [STRB_W-1:0]     wstrb;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write master ----------------
    typedef enum logic [1:0] {WM_IDLE, WM_AW, WM_W, WM_B} wm_state_t;
    wm_state_t wm_state, wm_next;
    logic [ADDR_WIDTH-1:0]    wm_addr;
    logic [16*DATA_WIDTH-1:0] wm_data;
    logic [3:0]               wm_len, wm_beat;

    always_comb begin
        wm_next = wm_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (wm_state)
            WM_IDLE: if (start_wr) wm_next = WM_AW;
            WM_AW: begin
                awvalid = 1'b1;
                if (awready) wm_next = WM_W;
            end
            WM_W: begin
                wvalid = 1'b1;
                if (wready && wlast) wm_next = WM_B;
            end
            WM_B: begin
                // only accept responses routed to this master's ID
                bready = (bid == MASTER_ID);
                if (bvalid && bready) wm_next = WM_IDLE;
            end
            default: wm_next = WM_IDLE;
        endcase
    end

    assign awid    = MASTER_ID;
    assign awaddr  = wm_addr;
    assign awlen   = {4'b0000, wm_len};
    assign awsize  = BEAT_SIZE;
    assign awburst = BURST_INCR;
    assign wdata   = wm_data[wm_beat*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb   = '1;
    assign wlast   = (wm_beat == wm_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wm_state <= WM_IDLE;
            wm_addr  <= '0;
            wm_data  <= '0;
            wm_len   <= '0;
            wm_beat  <= '0;
            wr_done  <= 1'b0;
        end else begin
            wm_state <= wm_next;
            wr_done  <= bvalid && bready;
            if (wm_state == WM_IDLE && start_wr) begin
                wm_addr <= wr_addr;
                wm_data <= wr_data;
                wm_len  <= (wr_len > 8'd15) ? 4'd15 : wr_len[3:0];
                wm_beat <= '0;
            end else if (wvalid && wready) begin
                wm_beat <= wm_beat + 4'd1;
            end
        end
    end

    // ---------------- write slave + RAM ----------------
    typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_RESP} ws_state_t;
    ws_state_t ws_state, ws_next;
    logic [ADDR_WIDTH-1:0] ws_addr, ws_incr;
    logic [ID_WIDTH-1:0]   ws_id;
    logic [7:0]            ws_len, ws_beat;
    logic                  ws_last;

    // burst ends on WLAST, or on the AWLEN count should a master drop WLAST
    assign ws_last = wlast || (ws_beat == ws_len);

    always_comb begin
        ws_next = ws_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (ws_state)
            WS_IDLE: begin
                awready = 1'b1;
                if (awvalid) ws_next = WS_DATA;
            end
            WS_DATA: begin
                wready = 1'b1;
                if (wvalid && ws_last) ws_next = WS_RESP;
            end
            WS_RESP: begin
                bvalid = 1'b1;
                if (bready) ws_next = WS_IDLE;
            end
            default: ws_next = WS_IDLE;
        endcase
    end

    assign bid = ws_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_state <= WS_IDLE;
            ws_addr  <= '0;
            ws_incr  <= '0;
            ws_id    <= '0;
            ws_len   <= '0;
            ws_beat  <= '0;
            mem      <= '{default: '0};
        end else begin
            ws_state <= ws_next;
            if (awvalid && awready) begin
                ws_addr <= awaddr;
                ws_id   <= awid;
                ws_len  <= awlen;
                ws_beat <= '0;
                ws_incr <= (awburst == BURST_INCR) ? (ADDR_WIDTH'(1) << awsize) : '0;
            end else if (wvalid && wready) begin
                ws_addr <= ws_addr + ws_incr;
                ws_beat <= ws_beat + 8'd1;
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) mem[ws_addr[BSHIFT +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read master ----------------
    typedef enum logic [1:0] {RM_IDLE, RM_AR, RM_R} rm_state_t;
    rm_state_t rm_state, rm_next;
    logic [ADDR_WIDTH-1:0] rm_addr;
    logic [3:0]            rm_len, rm_beat;

    always_comb begin
        rm_next = rm_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (rm_state)
            RM_IDLE: if (start_rd) rm_next = RM_AR;
            RM_AR: begin
                arvalid = 1'b1;
                if (arready) rm_next = RM_R;
            end
            RM_R: begin
                rready = (rid == MASTER_ID);
                if (rvalid && rready && rlast) rm_next = RM_IDLE;
            end
            default: rm_next = RM_IDLE;
        endcase
    end

    assign arid    = MASTER_ID;
    assign araddr  = rm_addr;
    assign arlen   = {4'b0000, rm_len};
    assign arsize  = BEAT_SIZE;
    assign arburst = BURST_INCR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rm_state <= RM_IDLE;
            rm_addr  <= '0;
            rm_len   <= '0;
            rm_beat  <= '0;
            rd_data  <= '0;
            rd_done  <= 1'b0;
        end else begin
            rm_state <= rm_next;
            rd_done  <= rvalid && rready && rlast;
            if (rm_state == RM_IDLE && start_rd) begin
                rm_addr <= rd_addr;
                rm_len  <= (rd_len > 8'd15) ? 4'd15 : rd_len[3:0];
                rm_beat <= '0;
                rd_data <= '0;
            end else if (rvalid && rready) begin
                rd_data[rm_beat*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                rm_beat <= rm_beat + 4'd1;
            end
        end
    end

    // ---------------- read slave ----------------
    typedef enum logic {RS_IDLE, RS_DATA} rs_state_t;
    rs_state_t rs_state, rs_next;
    logic [ADDR_WIDTH-1:0] rs_addr, rs_incr;
    logic [ID_WIDTH-1:0]   rs_id;
    logic [7:0]            rs_len, rs_beat;

    always_comb begin
        rs_next = rs_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rs_state)
            RS_IDLE: begin
                arready = 1'b1;
                if (arvalid) rs_next = RS_DATA;
            end
            RS_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) rs_next = RS_IDLE;
            end
            default: rs_next = RS_IDLE;
        endcase
    end

    // combinational RAM read: a same-cycle write lands at the edge, so the old word is returned
    assign rdata = mem[rs_addr[BSHIFT +: IDX_W]];
    assign rlast = (rs_beat == rs_len);
    assign rid   = rs_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_state <= RS_IDLE;
            rs_addr  <= '0;
            rs_incr  <= '0;
            rs_id    <= '0;
            rs_len   <= '0;
            rs_beat  <= '0;
        end else begin
            rs_state <= rs_next;
            if (arvalid && arready) begin
                rs_addr <= araddr;
                rs_id   <= arid;
                rs_len  <= arlen;
                rs_beat <= '0;
                rs_incr <= (arburst == BURST_INCR) ? (ADDR_WIDTH'(1) << arsize) : '0;
            end else if (rvalid && rready) begin
                rs_addr <= rs_addr + rs_incr;
                rs_beat <= rs_beat + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_top.sv
// Scoreboard bench for axi_top: stimulus pushes expected completions, a monitor
// pops and compares on every wr_done / rd_done pulse.
module tb_axi_top;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_wr = 1'b0, start_rd = 1'b0;
    logic [31:0]  wr_addr = '0, rd_addr = '0;
    logic [511:0] wr_data = '0;
    logic [7:0]   wr_len = '0, rd_len = '0;
    logic         wr_done, rd_done;
    logic [511:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  ref_mem [64];
    logic [31:0]  exp_wr_q [$];
    logic [511:0] exp_rd_q [$];

    axi_top #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .start_wr(start_wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len), .wr_done(wr_done),
        .start_rd(start_rd), .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data), .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word-addressed memory, index wraps modulo depth, burst clamped to 16 beats
    function automatic int unsigned beats(input logic [7:0] len);
        return (len > 8'd15) ? 16 : int'(len) + 1;
    endfunction

    function automatic logic [511:0] model_read(input logic [31:0] addr, input logic [7:0] len);
        logic [511:0] v = '0;
        for (int unsigned k = 0; k < beats(len); k++)
            v[k*32 +: 32] = ref_mem[((addr >> 2) + k) % 64];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [511:0] d);
        for (int unsigned k = 0; k < beats(len); k++)
            ref_mem[((addr >> 2) + k) % 64] = d[k*32 +: 32];
    endtask

    task automatic issue(input bit w, input logic [31:0] wa, input logic [7:0] wl, input logic [511:0] wd,
                         input bit r, input logic [31:0] ra, input logic [7:0] rl);
        @(posedge clk); #1;
        if (r) begin
            exp_rd_q.push_back(model_read(ra, rl));
            start_rd = 1'b1; rd_addr = ra; rd_len = rl;
        end
        if (w) begin
            model_write(wa, wl, wd);
            exp_wr_q.push_back(wa);
            start_wr = 1'b1; wr_addr = wa; wr_len = wl; wr_data = wd;
        end
        @(posedge clk); #1;
        start_wr = 1'b0; start_rd = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int cnt = 0;
        while (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            if (cnt >= budget) begin
                n_tests++; n_fail++;
                $display("FAIL %s: completion timeout after %0d cycles, pending wr=%0d rd=%0d required 0",
                         name, cnt, exp_wr_q.size(), exp_rd_q.size());
                exp_wr_q.delete(); exp_rd_q.delete();
                return;
            end
            @(posedge clk);
            cnt++;
        end
    endtask

    // Monitor: every done pulse must match a pending expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_done) begin
                n_tests++;
                if (exp_wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_done_unexpected: got pulse, required none");
                end else begin
                    void'(exp_wr_q.pop_front());
                end
            end
            if (rd_done) begin
                if (exp_rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_done_unexpected: got pulse, required none");
                end else begin
                    logic [511:0] e;
                    e = exp_rd_q.pop_front();
                    for (int w = 0; w < 16; w++)
                        check($sformatf("rd_word%0d", w), 512'(rd_data[w*32 +: 32]), 512'(e[w*32 +: 32]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic [31:0]  a;
        logic [7:0]   l;

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_wr_done", 512'(wr_done), 512'(0));
        check("reset_rd_done", 512'(rd_done), 512'(0));
        check("reset_rd_data", rd_data, '0);
        rst = 1'b0;

        // basic 4-beat write/read with latency bounds
        d = '0;
        d[31:0] = 32'hFACECAFE; d[63:32] = 32'hDEADBEEF; d[95:64] = 32'h12345678; d[127:96] = 32'h87654321;
        issue(1, 32'h0, 8'd3, d, 0, '0, '0);
        drain("wr4_latency", 10);
        issue(0, '0, '0, '0, 1, 32'h0, 8'd3);
        drain("rd4_latency", 8);

        // single beat, then earlier data intact
        d = '0; d[31:0] = 32'hA5A5A5A5;
        issue(1, 32'h10, 8'd0, d, 0, '0, '0);
        drain("wr1", 50);
        issue(0, '0, '0, '0, 1, 32'h10, 8'd0);
        drain("rd1", 50);
        issue(0, '0, '0, '0, 1, 32'h0, 8'd3);
        drain("rd4_again", 50);

        // full 16-beat burst and clamped len 20
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h1000 + k;
        issue(1, 32'h40, 8'd15, d, 0, '0, '0);
        drain("wr16", 60);
        issue(0, '0, '0, '0, 1, 32'h40, 8'd15);
        drain("rd16", 60);
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        issue(1, 32'h80, 8'd20, d, 0, '0, '0);
        drain("wr_clamp", 60);
        issue(0, '0, '0, '0, 1, 32'h80, 8'd20);
        drain("rd_clamp", 60);

        // never-written region, and addresses wrapping past MEM_DEPTH
        issue(0, '0, '0, '0, 1, 32'hC0, 8'd15);
        drain("rd_unwritten", 60);
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        issue(1, 32'hF8, 8'd3, d, 0, '0, '0);
        drain("wr_wrap_end", 60);
        issue(1, 32'h104, 8'd1, {d[255:0], d[511:256]}, 0, '0, '0);
        drain("wr_wrap_high", 60);
        issue(0, '0, '0, '0, 1, 32'hF8, 8'd7);
        drain("rd_wrap", 60);

        // start pulses while busy must be ignored
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        issue(1, 32'h50, 8'd7, d, 0, '0, '0);
        @(posedge clk); #1;
        start_wr = 1'b1; wr_addr = 32'h60; wr_len = 8'd3; wr_data = ~d;
        @(posedge clk); #1 start_wr = 1'b0;
        drain("wr_busy", 60);
        issue(0, '0, '0, '0, 1, 32'h40, 8'd15);
        @(posedge clk); #1;
        start_rd = 1'b1; rd_addr = 32'hC0; rd_len = 8'd0;
        @(posedge clk); #1 start_rd = 1'b0;
        drain("rd_busy", 60);
        repeat (20) @(posedge clk);
        issue(0, '0, '0, '0, 1, 32'h60, 8'd3);
        drain("rd_after_busy", 60);

        // concurrent write and read to disjoint words
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        issue(1, 32'h20, 8'd3, d, 1, 32'h40, 8'd3);
        drain("concurrent", 60);
        issue(0, '0, '0, '0, 1, 32'h20, 8'd3);
        drain("rd_concurrent_wr", 60);

        // randomized write/read pairs
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            l = 8'($urandom_range(0, 20));
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
            issue(1, a, l, d, 0, '0, '0);
            drain("rand_wr", 60);
            a = $urandom;
            l = 8'($urandom_range(0, 20));
            issue(0, '0, '0, '0, 1, a, l);
            drain("rand_rd", 60);
        end

        // reset during the W phase aborts the burst and clears RAM
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        issue(1, 32'h30, 8'd15, d, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("midrst_wr_done", 512'(wr_done), 512'(0));
        check("midrst_rd_data", rd_data, '0);
        exp_wr_q.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        issue(0, '0, '0, '0, 1, 32'h30, 8'd15);
        drain("rd_after_rst", 60);
        issue(0, '0, '0, '0, 1, 32'h0, 8'd15);
        drain("rd_low_after_rst", 60);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
